// File: rtl/reg_scan_display_pkg.sv
// Shared types and constants for the register-scan debug display.
// Holds the FSM state encoding, display geometry and the register-index wrap helper.
package reg_scan_display_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Next register index, wrapping from the last scanned register back to 0.
    function automatic logic [4:0] next_sel(input logic [4:0] sel, input logic [4:0] last);
        return (sel == last) ? 5'd0 : sel + 5'd1;
    endfunction

endpackage

// File: rtl/reg_scan_display_hex7seg.sv
// Combinational hex nibble to seven-segment decoder.
// Output is active-low {g,f,e,d,c,b,a}.
module hex7seg (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        // NOTE: every path assigns seg_n_o (default arm included), so no latch is inferred.
        unique case (nibble_i)
            4'h0:    seg_n_o = 7'h40;
            4'h1:    seg_n_o = 7'h79;
            4'h2:    seg_n_o = 7'h24;
            4'h3:    seg_n_o = 7'h30;
            4'h4:    seg_n_o = 7'h19;
            4'h5:    seg_n_o = 7'h12;
            4'h6:    seg_n_o = 7'h02;
            4'h7:    seg_n_o = 7'h78;
            4'h8:    seg_n_o = 7'h00;
            4'h9:    seg_n_o = 7'h10;
            4'hA:    seg_n_o = 7'h08;
            4'hB:    seg_n_o = 7'h03;
            4'hC:    seg_n_o = 7'h46;
            4'hD:    seg_n_o = 7'h21;
            4'hE:    seg_n_o = 7'h06;
            default: seg_n_o = 7'h0E;
        endcase
    end

endmodule

// File: rtl/reg_scan_display.sv
// Steps reg_sel through the computer's register file, snapshots reg_data and
// shows the 32-bit snapshot in hex on an 8-digit multiplexed seven-segment display.
module reg_scan_display
    import reg_scan_display_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int STEP_DIV = 100_000_000,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_auto,
    input  logic        step_req,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_sel,
    output logic [4:0]  cur_sel,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int STEP_W  = $clog2(STEP_DIV);
    localparam int DIGIT_W = $clog2(NUM_DIGITS);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_DIV - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);
    localparam logic [4:0]         SEL_LAST   = 5'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [DIGIT_W-1:0]  digit_q, digit_d;
    logic                step_prev_q;
    logic [4:0]          sel_q, sel_d;
    logic [4:0]          cur_sel_q, cur_sel_d;
    logic [31:0]         snap_q, snap_d;
    logic [7:0]          an_q, an_d;
    logic [7:0]          seg_q, seg_d;

    logic        step_tick;
    logic        step_rise;
    logic        advance;
    logic        capture_en;
    logic [3:0]  nibble;
    logic [6:0]  seg7_n;
    logic        dp_n;

    assign step_tick = en_auto && (step_cnt_q == STEP_LAST);
    assign step_rise = step_req && !step_prev_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) state_q <= ST_SETTLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SETTLE:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_HOLD;
            ST_HOLD:    if (advance) state_d = ST_SETTLE;
            default:    state_d = ST_SETTLE;
        endcase
    end

    // FSM: outputs. en_auto picks exactly one advance source, so a coincident tick and edge count once.
    always_comb begin
        capture_en = (state_q == ST_CAPTURE);
        advance    = (state_q == ST_HOLD) &&
                     ((en_auto && step_tick) || (!en_auto && step_rise));
    end

    always_comb begin
        step_cnt_d = '0;
        if (en_auto) step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + 1'b1;

        scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (scan_cnt_q == SCAN_LAST) digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;

        sel_d     = advance ? next_sel(sel_q, SEL_LAST) : sel_q;
        cur_sel_d = capture_en ? sel_q : cur_sel_q;
        snap_d    = capture_en ? reg_data : snap_q;
    end

    // Display path: an and seg both derive from digit_q so they always change together.
    assign nibble = snap_q[{digit_q, 2'b00} +: 4];
    assign dp_n   = !(!en_auto && (digit_q == DIGIT_LAST));

    hex7seg u_hex7seg (
        .nibble_i (nibble),
        .seg_n_o  (seg7_n)
    );

    always_comb begin
        an_d  = ~(8'd1 << digit_q);
        seg_d = {dp_n, seg7_n};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q  <= '0;
            scan_cnt_q  <= '0;
            digit_q     <= '0;
            step_prev_q <= 1'b0;
            sel_q       <= '0;
            cur_sel_q   <= '0;
            snap_q      <= '0;
            an_q        <= SEG_BLANK;
            seg_q       <= SEG_BLANK;
        end else begin
            step_cnt_q  <= step_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            step_prev_q <= step_req;
            sel_q       <= sel_d;
            cur_sel_q   <= cur_sel_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign reg_sel = sel_q;
    assign cur_sel = cur_sel_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule

// File: tb/tb_reg_scan_display.sv
// Scoreboard bench for reg_scan_display: stimulus queues expected select and
// display events, independent monitors pop and compare as the DUT produces them.
module tb_reg_scan_display;

    localparam int SCAN_DIV = 4;
    localparam int STEP_DIV = 16;
    localparam int NUM_REGS = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_auto = 1'b0;
    logic        step_req = 1'b0;
    logic        ovr = 1'b0;
    logic [31:0] reg_data;
    logic [4:0]  reg_sel, cur_sel;
    logic [7:0]  an, seg;

    // Register file stand-in; ovr substitutes a fixed pattern for display checks.
    assign reg_data = ovr ? 32'h0123_4567 : (32'hA000_0000 | {27'd0, reg_sel});

    always #5 clk = ~clk;

    reg_scan_display #(
        .SCAN_DIV (SCAN_DIV),
        .STEP_DIV (STEP_DIV),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en_auto  (en_auto),
        .step_req (step_req),
        .reg_data (reg_data),
        .reg_sel  (reg_sel),
        .cur_sel  (cur_sel),
        .an       (an),
        .seg      (seg)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] cs;
        int         gap;
    } sel_exp_t;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
    } disp_exp_t;

    sel_exp_t  sel_q[$];
    disp_exp_t disp_q[$];

    // Active-low {dp,g,f,e,d,c,b,a} with dp dark, digits 0..F.
    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;
    logic [4:0] prev_rs = '0, prev_cs = '0;
    logic [7:0] prev_an = 8'hFF;
    int   sel_gap = 0;
    int   disp_gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_sel(input logic [4:0] rs, input logic [4:0] cs, input int gap);
        sel_exp_t e;
        e.rs = rs; e.cs = cs; e.gap = gap;
        sel_q.push_back(e);
    endtask

    task automatic wait_sel_upto(input int left, input int max_cyc, input string name);
        int n = 0;
        while (sel_q.size() > left && n < max_cyc) begin
            tick(1);
            n++;
        end
        check(name, sel_q.size(), (sel_q.size() > left) ? left : sel_q.size());
        if (sel_q.size() > left) sel_q.delete();
    endtask

    // Sync to digit 7, then expect one full rotation 0..7 of the given snapshot.
    task automatic check_display(input logic [31:0] snap, input logic auto_mode, input string name);
        int n = 0;
        disp_exp_t d;
        do begin
            @(negedge clk);
            n++;
        end while (an != 8'h7F && n < 40);
        check({name, "_sync"}, an, 8'h7F);
        #1;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] nib;
            nib   = snap[4*i +: 4];
            d.an  = ~(8'd1 << i);
            d.seg = seg_tbl[nib];
            if (i == 7 && !auto_mode) d.seg = d.seg & 8'h7F;
            disp_q.push_back(d);
        end
        n = 0;
        while (disp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, disp_q.size(), 0);
        disp_q.delete();
    endtask

    // Register-select monitor: every change of (reg_sel, cur_sel) is one event.
    always @(negedge clk) begin
        if (mon_on) begin
            sel_gap++;
            if (reg_sel != prev_rs || cur_sel != prev_cs) begin
                if (sel_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_sel_event: reg_sel=%0d cur_sel=%0d, none expected (t=%0t)",
                             reg_sel, cur_sel, $time);
                end else begin
                    sel_exp_t e;
                    e = sel_q.pop_front();
                    check("reg_sel", reg_sel, e.rs);
                    check("cur_sel", cur_sel, e.cs);
                    if (e.gap != 0) check("sel_event_gap", sel_gap, e.gap);
                end
                prev_rs = reg_sel;
                prev_cs = cur_sel;
                sel_gap = 0;
            end
        end
    end

    // Display monitor: each digit-enable change is compared while expectations are queued.
    always @(negedge clk) begin
        if (mon_on) begin
            disp_gap++;
            if (an != prev_an) begin
                if (disp_q.size() != 0) begin
                    disp_exp_t d;
                    d = disp_q.pop_front();
                    check("an", an, d.an);
                    check("seg", seg, d.seg);
                    check("digit_hold", disp_gap, SCAN_DIV);
                end
                prev_an  = an;
                disp_gap = 0;
            end
        end
    end

    initial begin
        #50_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // 1. Reset for two clocks, then first capture.
        tick(2);
        rst    = 1'b0;
        mon_on = 1'b1;
        check("rst_reg_sel", reg_sel, 5'd0);
        check("rst_cur_sel", cur_sel, 5'd0);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 8'hFF);
        check_display(32'hA000_0000, 1'b0, "disp_reset");

        // 2. Auto step through all 32 registers and wrap to 0.
        for (int k = 1; k <= 32; k++) begin
            push_sel(5'(k % 32), 5'(k - 1), (k == 1) ? 0 : 14);
            push_sel(5'(k % 32), 5'(k % 32), 2);
        end
        en_auto = 1'b1;
        tick(15);
        check("auto_not_early", reg_sel, 5'd0);
        tick(1);
        check("auto_first_step", reg_sel, 5'd1);
        wait_sel_upto(0, 600, "auto_wrap_drained");

        // 3. Scan a fixed pattern while auto-stepping keeps recapturing it.
        ovr = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            push_sel(5'(k), 5'(k - 1), 14);
            push_sel(5'(k), 5'(k), 2);
        end
        wait_sel_upto(10, 40, "scan_first_capture");
        check_display(32'h0123_4567, 1'b1, "disp_scan");
        wait_sel_upto(0, 120, "scan_drained");
        en_auto = 1'b0;

        // 4. Manual mode: dp on digit 7, one advance for a long step_req level.
        check_display(32'h0123_4567, 1'b0, "disp_manual");
        tick(1);
        push_sel(5'd7, 5'd6, 0);
        push_sel(5'd7, 5'd7, 2);
        step_req = 1'b1;
        tick(10);
        step_req = 1'b0;
        wait_sel_upto(0, 20, "manual_drained");
        tick(8);

        // 5. Reset the cycle after an advance, while in SETTLE.
        push_sel(5'd8, 5'd7, 0);
        push_sel(5'd0, 5'd0, 0);
        step_req = 1'b1;
        tick(1);
        rst      = 1'b1;
        step_req = 1'b0;
        tick(1);
        check("midrst_reg_sel", reg_sel, 5'd0);
        check("midrst_cur_sel", cur_sel, 5'd0);
        check("midrst_an", an, 8'hFF);
        check("midrst_seg", seg, 8'hFF);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("post_rst_an", an, 8'hFE);
        check("post_rst_snapshot_cleared", seg, 8'hC0);
        tick(2);
        check("post_rst_capture", seg, 8'hF8);
        wait_sel_upto(0, 10, "midrst_drained");
        tick(4);

        // 6. Tick and step rise coincide, then a rise during CAPTURE is dropped.
        push_sel(5'd1, 5'd0, 0);
        push_sel(5'd1, 5'd1, 2);
        en_auto = 1'b1;
        tick(15);
        step_req = 1'b1;
        tick(1);
        en_auto  = 1'b0;
        step_req = 1'b0;
        tick(1);
        step_req = 1'b1;
        tick(3);
        step_req = 1'b0;
        tick(10);
        wait_sel_upto(0, 10, "collision_drained");
        check("collision_reg_sel", reg_sel, 5'd1);

        check("sel_queue_empty", sel_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
